// File: rtl/rc4_engine_if.sv
// Bundle of the rc4_engine start handshake and its S / ciphertext / plaintext memory ports.
// The engine connects through the slave modport; the requester and memory side use master.
interface rc4_engine_if #(
    parameter int KEY_BYTES = 3,
    parameter int MSG_AW    = 8
);
    logic                   valid;
    logic                   ready;
    logic [8*KEY_BYTES-1:0] key;
    logic [7:0]             s_addr;
    logic [7:0]             s_rddata;
    logic [7:0]             s_wrdata;
    logic                   s_wren;
    logic [MSG_AW-1:0]      ct_addr;
    logic [7:0]             ct_rddata;
    logic [MSG_AW-1:0]      pt_addr;
    logic [7:0]             pt_wrdata;
    logic                   pt_wren;
    logic [3:0]             fsm_state;

    modport master (
        output valid, key, s_rddata, ct_rddata,
        input  ready, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren, fsm_state
    );

    modport slave (
        input  valid, key, s_rddata, ct_rddata,
        output ready, s_addr, s_wrdata, s_wren, ct_addr, pt_addr, pt_wrdata, pt_wren, fsm_state
    );
endinterface

// File: rtl/rc4_engine.sv
// RC4 decrypt core: S-init, KSA, optional RC4-drop[N], then PRGA over a length-prefixed message.
// All memories are synchronous-read; every read result is consumed in the cycle after its address.
module rc4_engine #(
    parameter int KEY_BYTES = 3,
    parameter int DROP_N    = 0,
    parameter int MSG_AW    = 8
) (
    input  logic          clk,
    input  logic          rst,
    rc4_engine_if.slave   bus
);
    // Handshake: a request is taken on a rising edge where valid && ready; key is captured on that
    // edge and ready is low from the next cycle until the cycle after the final plaintext write.
    // valid while ready is low has no effect.

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_INIT   = 4'd1,
        S_KSA_RI = 4'd2,
        S_KSA_LI = 4'd3,
        S_KSA_RJ = 4'd4,
        S_KSA_WI = 4'd5,
        S_KSA_WJ = 4'd6,
        S_G_RI   = 4'd7,
        S_G_LI   = 4'd8,
        S_G_RJ   = 4'd9,
        S_G_WI   = 4'd10,
        S_G_WJ   = 4'd11,
        S_G_RP   = 4'd12,
        S_G_OUT  = 4'd13,
        S_LEN_RD = 4'd14,
        S_LEN_WR = 4'd15
    } state_t;

    localparam logic [10:0] DROP_LAST = 11'((DROP_N > 0) ? DROP_N - 1 : 0);
    localparam logic [4:0]  KIDX_LAST = 5'(KEY_BYTES - 1);

    state_t                 state, state_n;
    logic [7:0]             i, j, si, sj, idx, len;
    logic [4:0]             kidx;
    logic [10:0]            drop_cnt;
    logic                   dropping;
    logic [8*KEY_BYTES-1:0] key_r;
    logic [7:0]             key_byte;

    assign key_byte      = key_r[8*(KEY_BYTES-1-int'(kidx)) +: 8];
    assign bus.ct_addr   = MSG_AW'(idx);
    assign bus.fsm_state = state;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= S_IDLE;
        else     state <= state_n;
    end

    always_comb begin
        state_n       = state;
        bus.ready     = 1'b0;
        bus.s_addr    = 8'd0;
        bus.s_wrdata  = 8'd0;
        bus.s_wren    = 1'b0;
        bus.pt_addr   = '0;
        bus.pt_wrdata = 8'd0;
        bus.pt_wren   = 1'b0;
        case (state)
            S_IDLE: begin
                bus.ready = 1'b1;
                if (bus.valid) state_n = S_INIT;
            end
            S_INIT: begin
                bus.s_addr   = i;
                bus.s_wrdata = i;
                bus.s_wren   = 1'b1;
                if (i == 8'hFF) state_n = S_KSA_RI;
            end
            S_KSA_RI: begin
                bus.s_addr = i;
                state_n    = S_KSA_LI;
            end
            S_KSA_LI: state_n = S_KSA_RJ;
            S_KSA_RJ: begin
                bus.s_addr = j;
                state_n    = S_KSA_WI;
            end
            S_KSA_WI: begin
                bus.s_addr   = i;
                bus.s_wrdata = bus.s_rddata;
                bus.s_wren   = 1'b1;
                state_n      = S_KSA_WJ;
            end
            S_KSA_WJ: begin
                bus.s_addr   = j;
                bus.s_wrdata = si;
                bus.s_wren   = 1'b1;
                if (i != 8'hFF)      state_n = S_KSA_RI;
                else if (DROP_N > 0) state_n = S_G_RI;
                else                 state_n = S_LEN_RD;
            end
            S_G_RI: begin
                bus.s_addr = i;
                state_n    = S_G_LI;
            end
            S_G_LI: state_n = S_G_RJ;
            S_G_RJ: begin
                bus.s_addr = j;
                state_n    = S_G_WI;
            end
            S_G_WI: begin
                bus.s_addr   = i;
                bus.s_wrdata = bus.s_rddata;
                bus.s_wren   = 1'b1;
                state_n      = S_G_WJ;
            end
            S_G_WJ: begin
                bus.s_addr   = j;
                bus.s_wrdata = si;
                bus.s_wren   = 1'b1;
                state_n      = S_G_RP;
            end
            // After the swap S[i]=sj and S[j]=si, so their sum indexes the pad byte.
            S_G_RP: begin
                bus.s_addr = si + sj;
                state_n    = S_G_OUT;
            end
            S_G_OUT: begin
                if (dropping) begin
                    state_n = (drop_cnt == DROP_LAST) ? S_LEN_RD : S_G_RI;
                end else begin
                    bus.pt_addr   = MSG_AW'(idx);
                    bus.pt_wrdata = bus.ct_rddata ^ bus.s_rddata;
                    bus.pt_wren   = 1'b1;
                    state_n       = (idx == len) ? S_IDLE : S_G_RI;
                end
            end
            S_LEN_RD: state_n = S_LEN_WR;
            S_LEN_WR: begin
                bus.pt_wrdata = bus.ct_rddata;
                bus.pt_wren   = 1'b1;
                state_n       = (bus.ct_rddata == 8'd0) ? S_IDLE : S_G_RI;
            end
            default: state_n = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            i        <= 8'd0;
            j        <= 8'd0;
            si       <= 8'd0;
            sj       <= 8'd0;
            idx      <= 8'd0;
            len      <= 8'd0;
            kidx     <= 5'd0;
            drop_cnt <= 11'd0;
            dropping <= 1'b0;
            key_r    <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (bus.valid) begin
                        key_r    <= bus.key;
                        i        <= 8'd0;
                        j        <= 8'd0;
                        kidx     <= 5'd0;
                        idx      <= 8'd0;
                        dropping <= 1'b0;
                        drop_cnt <= 11'd0;
                    end
                end
                S_INIT: i <= i + 8'd1;
                S_KSA_LI: begin
                    si <= bus.s_rddata;
                    j  <= j + bus.s_rddata + key_byte;
                end
                S_KSA_WJ: begin
                    kidx <= (kidx == KIDX_LAST) ? 5'd0 : kidx + 5'd1;
                    if (i == 8'hFF) begin
                        // PRGA restarts from i=j=0; the first generated step uses i=1.
                        j <= 8'd0;
                        if (DROP_N > 0) begin
                            i        <= 8'd1;
                            dropping <= 1'b1;
                            drop_cnt <= 11'd0;
                        end else begin
                            i <= 8'd0;
                        end
                    end else begin
                        i <= i + 8'd1;
                    end
                end
                S_G_LI: begin
                    si <= bus.s_rddata;
                    j  <= j + bus.s_rddata;
                end
                S_G_WI: sj <= bus.s_rddata;
                S_G_OUT: begin
                    if (dropping) begin
                        drop_cnt <= drop_cnt + 11'd1;
                        if (drop_cnt == DROP_LAST) dropping <= 1'b0;
                        else                       i <= i + 8'd1;
                    end else if (idx == len) begin
                        idx <= 8'd0;
                    end else begin
                        idx <= idx + 8'd1;
                        i   <= i + 8'd1;
                    end
                end
                S_LEN_WR: begin
                    len <= bus.ct_rddata;
                    if (bus.ct_rddata != 8'd0) begin
                        idx <= 8'd1;
                        i   <= i + 8'd1;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
